output_vc_credit_ctrl: RTL and testbench

- Per-output-VC state and credit controller for the router.
- Tracks ownership of every output VC (N ports x M VCs) and downstream buffer credits.
- Drives the on_off mask into the VC/switch allocator cores and the vc_free vector into VC allocation.
- Enforces atomic VC reuse: an output VC is released only after its tail flit has left and every credit has returned.

---
 rtl/output_vc_credit_ctrl.sv | 110 +++++++++++
 tb/tb_output_vc_credit_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_vc_credit_ctrl.sv
// Per-output-VC ownership FSM and downstream credit counters; optional VC_CREDIT_ERROR_CHECK_EN adds sticky protocol_error.
// Latency: every input event shows on the outputs one cycle later (outputs decode flops only).
// Backpressure: on_off blocks switch allocation at zero credits; vc_free gates VC allocation.
module output_vc_credit_ctrl #(
    parameter int N            = 5,
    parameter int M            = 4,
    parameter int BUFFER_DEPTH = 8,
    localparam int CW          = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N-1:0][M-1:0]            vc_alloc_grant,
    input  logic [N-1:0][M-1:0]            flit_sent,
    input  logic [N-1:0][M-1:0]            flit_sent_tail,
    input  logic [N-1:0][M-1:0]            credit_in,
    output logic [N-1:0][M-1:0]            on_off,
    output logic [N-1:0][M-1:0]            vc_free,
    output logic [N-1:0][M-1:0][CW-1:0]    credit_count
`ifdef VC_CREDIT_ERROR_CHECK_EN
    ,
    output logic [N-1:0][M-1:0]            protocol_error
`endif
);

    typedef enum logic [1:0] {IDLE, ALLOCATED, ACTIVE, DRAIN} vc_state_e;

    localparam logic [CW-1:0] FULL = CW'(BUFFER_DEPTH);

    vc_state_e                     state_q [N][M];
    logic [N-1:0][M-1:0][CW-1:0]   cnt_q;
    logic [N-1:0][M-1:0][CW-1:0]   cnt_d;

    // Simultaneous send and credit cancel; a lone event saturates at 0 / FULL.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                if (flit_sent[i][j] && !credit_in[i][j] && cnt_q[i][j] != '0)
                    cnt_d[i][j] = cnt_q[i][j] - 1'b1;
                else if (credit_in[i][j] && !flit_sent[i][j] && cnt_q[i][j] != FULL)
                    cnt_d[i][j] = cnt_q[i][j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < M; j++) begin
                    state_q[i][j] <= IDLE;
                    cnt_q[i][j]   <= FULL;
                end
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < M; j++) begin
                    case (state_q[i][j])
                        IDLE:      if (vc_alloc_grant[i][j]) state_q[i][j] <= ALLOCATED;
                        ALLOCATED: if (flit_sent[i][j])
                                       state_q[i][j] <= flit_sent_tail[i][j] ? DRAIN : ACTIVE;
                        ACTIVE:    if (flit_sent[i][j] && flit_sent_tail[i][j])
                                       state_q[i][j] <= DRAIN;
                        // Release only once every outstanding credit is home.
                        DRAIN:     if (cnt_d[i][j] == FULL) state_q[i][j] <= IDLE;
                        default:   state_q[i][j] <= IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                on_off[i][j]  = (cnt_q[i][j] == '0);
                vc_free[i][j] = (state_q[i][j] == IDLE);
            end
        end
        credit_count = cnt_q;
    end

`ifdef VC_CREDIT_ERROR_CHECK_EN
    logic [N-1:0][M-1:0] err_q;
    logic [N-1:0][M-1:0] err_d;

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                if ((flit_sent[i][j] && !credit_in[i][j] && cnt_q[i][j] == '0) ||
                    (credit_in[i][j] && !flit_sent[i][j] && cnt_q[i][j] == FULL) ||
                    (vc_alloc_grant[i][j] && state_q[i][j] != IDLE) ||
                    (flit_sent[i][j] && (state_q[i][j] == IDLE || state_q[i][j] == DRAIN)) ||
                    (flit_sent_tail[i][j] && !flit_sent[i][j]) ||
                    (flit_sent[i][j] && $countones(flit_sent[i]) > 1))
                    err_d[i][j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    assign protocol_error = err_q;
`endif

endmodule

// File: tb/tb_output_vc_credit_ctrl.sv
// Self-checking bench: directed packet scenarios plus randomized traffic against an ownership/credit model.
module tb_output_vc_credit_ctrl;
    localparam int N  = 5;
    localparam int M  = 4;
    localparam int D  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0][M-1:0]         grant, sent, tail, cin;
    logic [N-1:0][M-1:0]         on_off, vc_free;
    logic [N-1:0][M-1:0][CW-1:0] cc;
`ifdef VC_CREDIT_ERROR_CHECK_EN
    logic [N-1:0][M-1:0]         perr;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Model: credits as integers, "owned" = handed out by allocation, "tail_done" = tail has left.
    int m_cred    [N][M];
    bit m_owned   [N][M];
    bit m_tdone   [N][M];
    bit m_err     [N][M];

    always #5 clk = ~clk;

    output_vc_credit_ctrl #(.N(N), .M(M), .BUFFER_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .vc_alloc_grant (grant),
        .flit_sent      (sent),
        .flit_sent_tail (tail),
        .credit_in      (cin),
        .on_off         (on_off),
        .vc_free        (vc_free),
        .credit_count   (cc)
`ifdef VC_CREDIT_ERROR_CHECK_EN
        ,
        .protocol_error (perr)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) begin
                m_cred[i][j] = D; m_owned[i][j] = 0; m_tdone[i][j] = 0; m_err[i][j] = 0;
            end
    endtask

    function automatic logic [N-1:0][M-1:0][CW-1:0] exp_cc();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) exp_cc[i][j] = CW'(m_cred[i][j]);
    endfunction

    function automatic logic [N-1:0][M-1:0] exp_free();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) exp_free[i][j] = !m_owned[i][j];
    endfunction

    function automatic logic [N-1:0][M-1:0] exp_onoff();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) exp_onoff[i][j] = (m_cred[i][j] == 0);
    endfunction

    function automatic logic [N-1:0][M-1:0] exp_err();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) exp_err[i][j] = m_err[i][j];
    endfunction

    task automatic clear_inputs();
        grant = '0; sent = '0; tail = '0; cin = '0;
    endtask

    // One clock: inputs are captured at the edge, model advances with the same inputs, inputs clear.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            int nsent = $countones(sent[i]);
            for (int j = 0; j < M; j++) begin
                int c  = m_cred[i][j];
                int nc = c - int'(sent[i][j]) + int'(cin[i][j]);
                if (nc < 0) nc = 0;
                if (nc > D) nc = D;
                if ((sent[i][j] && !cin[i][j] && c == 0) || (cin[i][j] && !sent[i][j] && c == D) ||
                    (grant[i][j] && m_owned[i][j]) || (sent[i][j] && (!m_owned[i][j] || m_tdone[i][j])) ||
                    (tail[i][j] && !sent[i][j]) || (sent[i][j] && nsent > 1))
                    m_err[i][j] = 1;
                if (m_owned[i][j] && m_tdone[i][j]) begin
                    if (nc == D) begin m_owned[i][j] = 0; m_tdone[i][j] = 0; end
                end else if (!m_owned[i][j]) begin
                    if (grant[i][j]) m_owned[i][j] = 1;
                end else if (sent[i][j] && tail[i][j]) begin
                    m_tdone[i][j] = 1;
                end
                m_cred[i][j] = nc;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) begin
                n_vec++;
                if (cc[i][j] !== 4'd8)
                    $display("FAIL reset_count[%0d][%0d] got %0d want 8", i, j, cc[i][j]);
                if (cc[i][j] !== 4'd8) n_bad++;
            end
        n_vec++;
        if (vc_free !== '1) begin n_bad++; $display("FAIL reset_vc_free got %h want all ones", vc_free); end
        n_vec++;
        if (on_off !== '0) begin n_bad++; $display("FAIL reset_on_off got %h want 0", on_off); end
    endtask

    task automatic test_packet();
        logic [CW-1:0] want;
        grant[1][2] = 1'b1;
        tick();
        n_vec++;
        if (vc_free[1][2] !== 1'b0) begin n_bad++; $display("FAIL pkt_grant_free got %b want 0", vc_free[1][2]); end
        for (int k = 0; k < 4; k++) begin
            sent[1][2] = 1'b1;
            tail[1][2] = (k == 3);
            tick();
            want = CW'(7 - k);
            n_vec++;
            if (cc[1][2] !== want) begin n_bad++; $display("FAIL pkt_send_count[%0d] got %0d want %0d", k, cc[1][2], want); end
        end
        tick(); tick();
        n_vec++;
        if (vc_free[1][2] !== 1'b0) begin n_bad++; $display("FAIL pkt_drain_free got %b want 0", vc_free[1][2]); end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (vc_free[1][2] !== 1'b0) begin n_bad++; $display("FAIL pkt_early_release[%0d] got %b want 0", k, vc_free[1][2]); end
            cin[1][2] = 1'b1;
            tick();
            want = CW'(5 + k);
            n_vec++;
            if (cc[1][2] !== want) begin n_bad++; $display("FAIL pkt_credit_count[%0d] got %0d want %0d", k, cc[1][2], want); end
            n_vec++;
            if (on_off[1][2] !== 1'b0) begin n_bad++; $display("FAIL pkt_on_off[%0d] got %b want 0", k, on_off[1][2]); end
        end
        n_vec++;
        if (vc_free[1][2] !== 1'b1) begin n_bad++; $display("FAIL pkt_release got %b want 1", vc_free[1][2]); end
    endtask

    task automatic test_on_off();
        grant[0][0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            sent[0][0] = 1'b1;
            tick();
        end
        n_vec++;
        if (cc[0][0] !== 4'd0) begin n_bad++; $display("FAIL onoff_count got %0d want 0", cc[0][0]); end
        n_vec++;
        if (on_off[0][0] !== 1'b1) begin n_bad++; $display("FAIL onoff_set got %b want 1", on_off[0][0]); end
        sent[0][0] = 1'b1; cin[0][0] = 1'b1;
        tick();
        n_vec++;
        if (cc[0][0] !== 4'd0 || on_off[0][0] !== 1'b1) begin
            n_bad++; $display("FAIL onoff_cancel got cnt %0d on_off %b want 0/1", cc[0][0], on_off[0][0]);
        end
        sent[0][0] = 1'b1; tail[0][0] = 1'b1; cin[0][0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin cin[0][0] = 1'b1; tick(); end
        n_vec++;
        if (cc[0][0] !== 4'd8 || vc_free[0][0] !== 1'b1 || on_off[0][0] !== 1'b0) begin
            n_bad++; $display("FAIL onoff_recover got cnt %0d free %b on_off %b want 8/1/0", cc[0][0], vc_free[0][0], on_off[0][0]);
        end
    endtask

    task automatic test_single_flit();
        grant[3][1] = 1'b1;
        tick();
        sent[3][1] = 1'b1; tail[3][1] = 1'b1; cin[3][1] = 1'b1;
        tick();
        n_vec++;
        if (cc[3][1] !== 4'd8 || vc_free[3][1] !== 1'b0) begin
            n_bad++; $display("FAIL single_drain got cnt %0d free %b want 8/0", cc[3][1], vc_free[3][1]);
        end
        grant[3][1] = 1'b1;
        tick();
        n_vec++;
        if (vc_free[3][1] !== 1'b1) begin n_bad++; $display("FAIL single_idle got %b want 1", vc_free[3][1]); end
        tick();
        n_vec++;
        if (vc_free[3][1] !== 1'b1) begin n_bad++; $display("FAIL single_grant_ignored got %b want 1", vc_free[3][1]); end
    endtask

`ifdef VC_CREDIT_ERROR_CHECK_EN
    task automatic test_error();
        logic [N-1:0][M-1:0] want;
        cin[4][3] = 1'b1;
        tick();
        n_vec++;
        if (cc[4][3] !== 4'd8 || perr[4][3] !== 1'b1) begin
            n_bad++; $display("FAIL err_overflow got cnt %0d err %b want 8/1", cc[4][3], perr[4][3]);
        end
        for (int k = 0; k < 5; k++) tick();
        want = exp_err();
        n_vec++;
        if (perr !== want || perr[4][3] !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %h want %h", perr, want); end
    endtask
`endif

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int j = $urandom_range(0, M - 1);
                    sent[i][j] = 1'b1;
                    tail[i][j] = ($urandom_range(0, 3) == 0);
                end
                if ($urandom_range(0, 39) == 0) sent[i][$urandom_range(0, M - 1)] = 1'b1;
                if ($urandom_range(0, 39) == 0) tail[i][$urandom_range(0, M - 1)] = 1'b1;
                for (int j = 0; j < M; j++) begin
                    if ($urandom_range(0, 7) == 0) grant[i][j] = 1'b1;
                    if ($urandom_range(0, 3) == 0) cin[i][j]   = 1'b1;
                end
            end
            tick();
            n_vec++;
            if (cc !== exp_cc()) begin n_bad++; $display("FAIL rand_count cyc %0d got %h want %h", cyc, cc, exp_cc()); end
            n_vec++;
            if (vc_free !== exp_free()) begin n_bad++; $display("FAIL rand_free cyc %0d got %h want %h", cyc, vc_free, exp_free()); end
            n_vec++;
            if (on_off !== exp_onoff()) begin n_bad++; $display("FAIL rand_on_off cyc %0d got %h want %h", cyc, on_off, exp_onoff()); end
`ifdef VC_CREDIT_ERROR_CHECK_EN
            n_vec++;
            if (perr !== exp_err()) begin n_bad++; $display("FAIL rand_err cyc %0d got %h want %h", cyc, perr, exp_err()); end
`endif
        end
    endtask

    task automatic test_async_reset();
        grant[2][0] = 1'b1;
        tick();
        sent[2][0] = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (cc[2][0] !== 4'd8 || vc_free !== '1 || on_off !== '0) begin
            n_bad++; $display("FAIL async_reset got cnt %0d free %h on_off %h want 8/all1/0", cc[2][0], vc_free, on_off);
        end
        n_vec++;
        if (cc !== exp_cc()) begin n_bad++; $display("FAIL async_reset_counts got %h want %h", cc, exp_cc()); end
`ifdef VC_CREDIT_ERROR_CHECK_EN
        n_vec++;
        if (perr !== '0) begin n_bad++; $display("FAIL async_reset_err got %h want 0", perr); end
`endif
        #3;
        reset = 1'b0;
        tick();
        n_vec++;
        if (vc_free !== exp_free() || cc !== exp_cc()) begin
            n_bad++; $display("FAIL post_reset got free %h want %h", vc_free, exp_free());
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_on_off();
        test_single_flit();
`ifdef VC_CREDIT_ERROR_CHECK_EN
        test_error();
`endif
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
